// File: rtl/mac_out_packer.sv
// Output stage after the MAC adder tree: packs result bytes into 32-bit words and buffers them.
// Optional ReLU on the byte stream is enabled by defining OUT_RELU_EN.
module mac_out_packer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             vld_i,
  input  logic [7:0]       acc_i,
  input  logic             last_i,
  input  logic             clr_i,
  output logic [31:0]      dout,
  output logic [3:0]       dout_keep,
  output logic             dout_last,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             ovf_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } word_t;

  logic [1:0]       cnt;
  logic [31:0]      asm_data;
  logic [3:0]       asm_keep;
  word_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [7:0]       byte_c;
  word_t            word_c;
  word_t            head_c;
  logic             complete_c;
  logic             full_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;
  logic [PTR_W-1:0] rd_nxt_c;
  logic [LVL_W-1:0] lvl_nxt_c;

  // Byte stage, word assembly and FIFO push/pop decisions
  always_comb begin
    byte_c = acc_i;
`ifdef OUT_RELU_EN
    if (acc_i[7]) byte_c = 8'h00;
`endif
    word_c.data = asm_data;
    word_c.keep = asm_keep;
    word_c.last = last_i;
    if (vld_i) begin
      word_c.data[{cnt, 3'b000} +: 8] = byte_c;
      word_c.keep[cnt]                = 1'b1;
    end

    complete_c = (vld_i && (cnt == 2'd3 || last_i)) ||
                 (!vld_i && last_i && cnt != 2'd0);
    full_c     = (level_o == LVL_W'(FIFO_DEPTH));
    pop_c      = dout_vld && dout_rdy;
    push_c     = complete_c && (!full_c || pop_c);
    drop_c     = complete_c && full_c && !pop_c;
    rd_nxt_c   = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
    lvl_nxt_c  = level_o + LVL_W'(push_c) - LVL_W'(pop_c);

    // Next head: a word pushed into the slot about to become head bypasses the array
    head_c = mem[rd_nxt_c];
    if (push_c && wr_ptr == rd_nxt_c) head_c = word_c;
    if (lvl_nxt_c == '0)               head_c = '0;
  end

  // Word storage; contents are only observed through the level-gated head register
  always_ff @(posedge clk) begin
    if (push_c && !clr_i) mem[wr_ptr] <= word_c;
  end

  // Packer state, pointers, flags and registered head
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      asm_data  <= '0;
      asm_keep  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_o   <= '0;
      ovf_o     <= 1'b0;
      dout      <= '0;
      dout_keep <= '0;
      dout_last <= 1'b0;
      dout_vld  <= 1'b0;
    end else if (clr_i) begin
      cnt       <= '0;
      asm_data  <= '0;
      asm_keep  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_o   <= '0;
      ovf_o     <= 1'b0;
      dout      <= '0;
      dout_keep <= '0;
      dout_last <= 1'b0;
      dout_vld  <= 1'b0;
    end else begin
      if (complete_c) begin
        cnt      <= '0;
        asm_data <= '0;
        asm_keep <= '0;
      end else if (vld_i) begin
        cnt      <= cnt + 2'd1;
        asm_data <= word_c.data;
        asm_keep <= word_c.keep;
      end
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_nxt_c;
      level_o   <= lvl_nxt_c;
      ovf_o     <= ovf_o | drop_c;
      dout      <= head_c.data;
      dout_keep <= head_c.keep;
      dout_last <= head_c.last;
      dout_vld  <= (lvl_nxt_c != '0);
    end
  end

endmodule

// File: tb/tb_mac_out_packer.sv
// Directed self-checking bench for mac_out_packer; expectations follow OUT_RELU_EN when defined.
module tb_mac_out_packer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          vld_i = 1'b0;
  logic [7:0]    acc_i = 8'h00;
  logic          last_i = 1'b0;
  logic          clr_i = 1'b0;
  logic          dout_rdy = 1'b0;
  logic [31:0]   dout;
  logic [3:0]    dout_keep;
  logic          dout_last;
  logic          dout_vld;
  logic          ovf_o;
  logic [LW-1:0] level_o;

  int errs = 0;
  int checks = 0;

  mac_out_packer #(.FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
    .clk(clk), .rstn(rstn), .vld_i(vld_i), .acc_i(acc_i), .last_i(last_i),
    .clr_i(clr_i), .dout(dout), .dout_keep(dout_keep), .dout_last(dout_last),
    .dout_vld(dout_vld), .dout_rdy(dout_rdy), .ovf_o(ovf_o), .level_o(level_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xf(input logic [7:0] a);
`ifdef OUT_RELU_EN
    return a[7] ? 8'h00 : a;
`else
    return a;
`endif
  endfunction

  task automatic send(input logic [7:0] b, input logic l);
    vld_i = 1'b1; acc_i = b; last_i = l;
    @(negedge clk);
    vld_i = 1'b0; acc_i = 8'h00; last_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (dout !== 32'h0) begin errs++; $display("FAIL reset_dout: got %h exp 0", dout); end
    checks++; if (dout_keep !== 4'h0) begin errs++; $display("FAIL reset_keep: got %h exp 0", dout_keep); end
    checks++; if (dout_last !== 1'b0) begin errs++; $display("FAIL reset_last: got %b exp 0", dout_last); end
    checks++; if (dout_vld !== 1'b0) begin errs++; $display("FAIL reset_vld: got %b exp 0", dout_vld); end
    checks++; if (ovf_o !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b exp 0", ovf_o); end
    checks++; if (level_o !== 4'd0) begin errs++; $display("FAIL reset_level: got %0d exp 0", level_o); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pack();
    logic [31:0] e;
`ifdef OUT_RELU_EN
    e = 32'h007F0001;
`else
    e = 32'hFF7F8201;
`endif
    dout_rdy = 1'b1;
    send(8'h01, 1'b0); send(8'h82, 1'b0); send(8'h7F, 1'b0);
    checks++; if (dout_vld !== 1'b0) begin errs++; $display("FAIL pack_early_vld: got %b exp 0", dout_vld); end
    send(8'hFF, 1'b0);
    checks++; if (dout_vld !== 1'b1) begin errs++; $display("FAIL pack_vld: got %b exp 1", dout_vld); end
    checks++; if (dout !== e) begin errs++; $display("FAIL pack_data: got %h exp %h", dout, e); end
    checks++; if (dout_keep !== 4'hF) begin errs++; $display("FAIL pack_keep: got %h exp f", dout_keep); end
    checks++; if (dout_last !== 1'b0) begin errs++; $display("FAIL pack_last: got %b exp 0", dout_last); end
    @(negedge clk);
    checks++; if (dout_vld !== 1'b0 || level_o !== 4'd0) begin
      errs++; $display("FAIL pack_pop: got vld=%b level=%0d exp vld=0 level=0", dout_vld, level_o);
    end
    dout_rdy = 1'b0;
  endtask

  task automatic test_partial();
    dout_rdy = 1'b0;
    send(8'h11, 1'b0); send(8'h22, 1'b1);
    checks++; if (dout !== 32'h00002211) begin errs++; $display("FAIL partial_data: got %h exp 00002211", dout); end
    checks++; if (dout_keep !== 4'h3) begin errs++; $display("FAIL partial_keep: got %h exp 3", dout_keep); end
    checks++; if (dout_last !== 1'b1) begin errs++; $display("FAIL partial_last: got %b exp 1", dout_last); end
    checks++; if (level_o !== 4'd1) begin errs++; $display("FAIL partial_level: got %0d exp 1", level_o); end
    dout_rdy = 1'b1;
    @(negedge clk);
    dout_rdy = 1'b0;
    last_i = 1'b1;
    @(negedge clk);
    last_i = 1'b0;
    @(negedge clk);
    checks++; if (dout_vld !== 1'b0 || level_o !== 4'd0) begin
      errs++; $display("FAIL lone_last: got vld=%b level=%0d exp vld=0 level=0", dout_vld, level_o);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] ew [9];
    logic [7:0]  b;
    pulse_clr();
    dout_rdy = 1'b0;
    for (int w = 0; w < 9; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(8 * w + k + 1);
        ew[w][8*k +: 8] = xf(b);
        send(b, 1'b0);
      end
      if (w == 7) begin
        checks++; if (level_o !== 4'd8 || ovf_o !== 1'b0) begin
          errs++; $display("FAIL ovf_at_full: got level=%0d ovf=%b exp level=8 ovf=0", level_o, ovf_o);
        end
      end
    end
    checks++; if (level_o !== 4'd8) begin errs++; $display("FAIL ovf_level: got %0d exp 8", level_o); end
    checks++; if (ovf_o !== 1'b1) begin errs++; $display("FAIL ovf_flag: got %b exp 1", ovf_o); end
    dout_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (dout_vld !== 1'b1 || dout !== ew[i]) begin
        errs++; $display("FAIL ovf_drain%0d: got vld=%b data=%h exp vld=1 data=%h", i, dout_vld, dout, ew[i]);
      end
      @(negedge clk);
    end
    dout_rdy = 1'b0;
    checks++; if (dout_vld !== 1'b0) begin errs++; $display("FAIL ovf_ninth_absent: got vld=%b exp 0", dout_vld); end
    checks++; if (ovf_o !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b exp 1", ovf_o); end
    pulse_clr();
    checks++; if (ovf_o !== 1'b0 || level_o !== 4'd0) begin
      errs++; $display("FAIL ovf_clr: got ovf=%b level=%0d exp ovf=0 level=0", ovf_o, level_o);
    end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] ew [9];
    logic [7:0]  b;
    dout_rdy = 1'b0;
    for (int w = 0; w < 9; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(8'h40 + 4 * w + k);
        ew[w][8*k +: 8] = xf(b);
        if (w == 8 && k == 3) dout_rdy = 1'b1;
        send(b, 1'b0);
      end
    end
    dout_rdy = 1'b0;
    checks++; if (level_o !== 4'd8) begin errs++; $display("FAIL pp_level: got %0d exp 8", level_o); end
    checks++; if (ovf_o !== 1'b0) begin errs++; $display("FAIL pp_ovf: got %b exp 0", ovf_o); end
    dout_rdy = 1'b1;
    for (int i = 1; i < 9; i++) begin
      checks++; if (dout_vld !== 1'b1 || dout !== ew[i]) begin
        errs++; $display("FAIL pp_drain%0d: got vld=%b data=%h exp vld=1 data=%h", i, dout_vld, dout, ew[i]);
      end
      @(negedge clk);
    end
    dout_rdy = 1'b0;
    checks++; if (dout_vld !== 1'b0) begin errs++; $display("FAIL pp_empty: got vld=%b exp 0", dout_vld); end
  endtask

  task automatic test_reset_midword();
    logic [31:0] e;
    dout_rdy = 1'b0;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
    send(8'h05, 1'b0); send(8'h06, 1'b0);
    #2 rstn = 1'b0;
    #1;
    checks++; if (dout !== 32'h0 || dout_keep !== 4'h0 || dout_last !== 1'b0 ||
                  dout_vld !== 1'b0 || ovf_o !== 1'b0 || level_o !== 4'd0) begin
      errs++; $display("FAIL async_reset: got data=%h keep=%h last=%b vld=%b ovf=%b level=%0d exp all 0",
                       dout, dout_keep, dout_last, dout_vld, ovf_o, level_o);
    end
    @(negedge clk);
    rstn = 1'b1;
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0); send(8'hA4, 1'b0);
    e = {xf(8'hA4), xf(8'hA3), xf(8'hA2), xf(8'hA1)};
    checks++; if (dout !== e) begin errs++; $display("FAIL rst_word_data: got %h exp %h", dout, e); end
    checks++; if (dout_keep !== 4'hF || level_o !== 4'd1) begin
      errs++; $display("FAIL rst_word_keep: got keep=%h level=%0d exp keep=f level=1", dout_keep, level_o);
    end
    pulse_clr();
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] cur, prev_dout, e;
    logic        prev_hold;
    logic [7:0]  b;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; prev_hold = 1'b0; prev_dout = '0; cur = '0;
    while (got < 16 && cyc < 600) begin
      if (prev_hold) begin
        checks++; if (dout !== prev_dout) begin
          errs++; $display("FAIL b2b_stable: got %h exp %h", dout, prev_dout);
        end
      end
      dout_rdy = ($urandom_range(0, 3) != 0);
      if (dout_vld && dout_rdy) begin
        e = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (dout !== e || dout_keep !== 4'hF) begin
          errs++; $display("FAIL b2b_word%0d: got data=%h keep=%h exp data=%h keep=f", got, dout, dout_keep, e);
        end
        got++;
      end
      prev_hold = dout_vld && !dout_rdy;
      prev_dout = dout;
      if (sent < 64) begin
        b = 8'($urandom_range(0, 255));
        vld_i = 1'b1; acc_i = b;
        cur[8*(sent % 4) +: 8] = xf(b);
        if (sent % 4 == 3) q.push_back(cur);
        sent++;
      end else begin
        vld_i = 1'b0; acc_i = 8'h00;
      end
      @(negedge clk);
      cyc++;
    end
    vld_i = 1'b0; dout_rdy = 1'b0;
    checks++; if (got != 16) begin errs++; $display("FAIL b2b_count: got %0d words exp 16", got); end
    checks++; if (ovf_o !== 1'b0) begin errs++; $display("FAIL b2b_ovf: got %b exp 0", ovf_o); end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_partial();
    test_overflow();
    test_full_pushpop();
    test_reset_midword();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mac_out_packer.md
# mac_out_packer

Output stage directly downstream of the MAC adder tree. Takes the tree's 8-bit result stream (one byte per valid cycle, no backpressure) and optionally applies ReLU. Packs four results per 32-bit word and buffers the words in a small FIFO. Words are presented to the output bus through a valid/ready handshake. Because the adder pipeline cannot stall, this block absorbs downstream backpressure and flags any overflow.

## Interface
- `FIFO_DEPTH`, 8: word entries in the output FIFO; power of two, ≥ 2.
- `LVL_W`, `$clog2(FIFO_DEPTH)+1`: width of `level_o`.

- `clk` in 1: single clock; all logic on the rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `vld_i` in 1: `acc_i` is valid this cycle.
- `acc_i` in 8: signed result byte from the adder tree.
- `last_i` in 1: ends the current group; flushes the partial word. Sampled every cycle, with or without `vld_i`.
- `clr_i` in 1: synchronous clear of the packer, the FIFO and `ovf_o`.
- `dout` out 32: head word; lane k is bits [8k+7:8k], and lane 0 holds the first byte.
- `dout_keep` out 4: lane-valid mask of the head word.
- `dout_last` out 1: the head word closed a group.
- `dout_vld` out 1: FIFO not empty.
- `dout_rdy` in 1: consumer accepts the head word when `dout_vld && dout_rdy`.
- `ovf_o` out 1: sticky flag; a completed word was dropped.
- `level_o` out LVL_W: FIFO occupancy, 0..FIFO_DEPTH.

## Operation
- **Byte stage:** on `vld_i`, compute b = ReLU(`acc_i`) when `OUT_RELU_EN` is defined, otherwise b = `acc_i`. Write b into lane `cnt` of the assembly register and set `keep[cnt]`.
- **Byte counter `cnt`** (2 bits, 0..3). It increments on each `vld_i`.
- **Word completion** happens when any of the following holds; then `cnt` returns to 0 and the assembly register and keep bits clear:
  - `vld_i && cnt==3`;
  - `vld_i && last_i`: the current byte is included;
  - `!vld_i && last_i && cnt!=0`.
- **Ignored `last_i`:** when `!vld_i && last_i && cnt==0`, `last_i` has no effect.
- **Completed-word contents:** unused lanes are 0. The keep mask marks written lanes, always a contiguous prefix (0x1, 0x3, 0x7, 0xF). The last bit is 1 if `last_i` caused or accompanied completion.
- **Push rule:** a completed word is pushed unless the FIFO is full with no pop in the same cycle.
  - Full with a simultaneous pop: the push is accepted and the level stays at FIFO_DEPTH.
  - Full without a pop: the word is dropped, the FIFO is unchanged, and `ovf_o` is set.
- **Pop:** `dout_vld && dout_rdy`. The head advances and the next word appears the following cycle. A pop is never issued when empty, and `dout_rdy` is ignored while `dout_vld=0`.
- **Pointers:** read and write pointers wrap modulo FIFO_DEPTH. `level_o` = pushes − pops and updates on both.
- **`clr_i`:** in the cycle it is sampled, it overrides `vld_i`, `last_i`, push and pop. Afterwards `cnt=0`, the assembly register is 0, the FIFO is empty and `ovf_o=0`.
- **`ovf_o`:** cleared only by reset or `clr_i`.

## Timing
- **Reset values:** `dout=0`, `dout_keep=0`, `dout_last=0`, `dout_vld=0`, `ovf_o=0`, `level_o=0`. `cnt=0`, pointers are 0 and the assembly register is 0.
- **Reset mid-word:** asserting reset mid-word discards the partial word. The first byte after reset lands in lane 0.
- **Latency:** the completing byte is sampled at edge N and the word is in the FIFO after edge N. If the FIFO was empty, `dout_vld` rises in cycle N+1 with the word on `dout`.
- **Output timing:** `dout`, `dout_keep` and `dout_last` are read from the FIFO head and are stable while `dout_vld && !dout_rdy`.
- **Throughput:** 1 byte per cycle in. Output is 1 word per cycle; sustained input needs a consumer ready ≥ 25% of cycles.
- **ovf_o timing:** `ovf_o` rises the cycle after the dropped push.

## Configuration
- **`OUT_RELU_EN` defined:** b = `acc_i[7]` ? 8'h00 : `acc_i`, so negative results are clamped to zero.
- **`OUT_RELU_EN` undefined:** `acc_i` is stored unmodified as two's complement.
- All other behaviour is identical in both builds.

## Test plan
- **ReLU packing:** with `OUT_RELU_EN`, bytes 0x01, 0x82, 0x7F, 0xFF on consecutive cycles and `dout_rdy=1` → one word 0x007F0001, keep 0xF, last 0, `dout_vld` one cycle after the 4th byte. The same stimulus without the macro → 0xFF7F8201.
- **Partial flush:** bytes 0x11, 0x22 with `last_i` on the second → 0x00002211, keep 0x3, last 1. A later `last_i` alone with `cnt==0` produces no word.
- **Overflow:** hold `dout_rdy=0` and push 9 full words (FIFO_DEPTH=8) → `level_o=8`, `ovf_o=1` after the 9th. Draining returns words 1–8 in order and the 9th is absent; `ovf_o` stays 1 until `clr_i`.
- **Push and pop at full:** FIFO full, word completes in the same cycle as a pop → no drop, `ovf_o=0`, `level_o` stays 8, and the new word emerges last.
- **Reset mid-word:** after 2 bytes, pulse `rstn` low asynchronously mid-cycle → all outputs 0 immediately. Bytes 0xA1..0xA4 afterwards → 0xA4A3A2A1, keep 0xF.
- **Backpressure hold:** toggle `dout_rdy` randomly while streaming 64 bytes → 16 words, in order and bit-exact against a model, with `dout` stable whenever `dout_vld && !dout_rdy`.
